ksa_pipe_adder: RTL and testbench

KSA_PIPE_ADDER -- requirements
Module: ksa_pipe_adder

---
 rtl/ksa_pipe_adder.sv | 195 +++++++++++++++++++
 tb/tb_ksa_pipe_adder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ksa_pipe_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake.
// One operand register stage, one register per prefix level and one output
// register. All stages advance together and hold together when the output
// is valid but not accepted.
module ksa_pipe_adder #(
  parameter int WIDTH = 32
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int LVL = $clog2(WIDTH);

  if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 32 || WIDTH == 64)) begin : g_width_check
    $error("ksa_pipe_adder: WIDTH must be 8, 16, 32 or 64");
  end

  logic stall;
  logic advance;
  logic out_valid_q;

  // Global stall: the whole pipe holds while the output waits for the consumer.
  always_comb begin
    stall   = out_valid_q & ~out_ready;
    advance = ~stall;
  end

  assign in_ready = advance;

  // ---------------- Stage 0: operand conditioning ----------------
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] s0_g_d, s0_g_q, s0_p_d, s0_p_q;
  logic             s0_c0_d, s0_c0_q;
  logic             s0_am_d, s0_am_q;
  logic             s0_bm_d, s0_bm_q;
  logic             s0_v_d, s0_v_q;

  // Invert B for subtraction and form per-bit generate/propagate.
  always_comb begin
    b_eff   = in_sub ? ~in_b : in_b;
    s0_g_d  = in_a & b_eff;
    s0_p_d  = in_a ^ b_eff;
    s0_c0_d = in_sub | in_cin;
    s0_am_d = in_a[WIDTH-1];
    s0_bm_d = b_eff[WIDTH-1];
    s0_v_d  = in_valid;
  end

  // Stage 0 valid bit.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s0_v_q <= 1'b0;
    end else if (advance) begin
      s0_v_q <= s0_v_d;
    end
  end

  // Stage 0 datapath.
  always_ff @(posedge wb_clk_i) begin
    if (advance) begin
      s0_g_q  <= s0_g_d;
      s0_p_q  <= s0_p_d;
      s0_c0_q <= s0_c0_d;
      s0_am_q <= s0_am_d;
      s0_bm_q <= s0_bm_d;
    end
  end

  // ---------------- Stages 1..LVL: prefix levels ----------------
  for (genvar k = 1; k <= LVL; k++) begin : g_lvl
    localparam int D = 1 << (k - 1);

    logic [WIDTH-1:0] g_in, p_in, po_in;
    logic             c0_in, am_in, bm_in, v_in;
    logic [WIDTH-1:0] g_d, g_q, po_q;
    logic             c0_q, am_q, bm_q, v_q;

    if (k == 1) begin : g_src
      // Carry-in folded into bit 0 so every group generate already includes it.
      always_comb begin
        g_in  = {s0_g_q[WIDTH-1:1], s0_g_q[0] | (s0_p_q[0] & s0_c0_q)};
        p_in  = s0_p_q;
        po_in = s0_p_q;
        c0_in = s0_c0_q;
        am_in = s0_am_q;
        bm_in = s0_bm_q;
        v_in  = s0_v_q;
      end
    end else begin : g_src
      // Take the previous prefix level's registers.
      always_comb begin
        g_in  = g_lvl[k-1].g_q;
        p_in  = g_lvl[k-1].g_p.p_q;
        po_in = g_lvl[k-1].po_q;
        c0_in = g_lvl[k-1].c0_q;
        am_in = g_lvl[k-1].am_q;
        bm_in = g_lvl[k-1].bm_q;
        v_in  = g_lvl[k-1].v_q;
      end
    end

    // Combine bit i with bit i-D; low D bits pass through.
    always_comb begin
      g_d = g_in | (p_in & {g_in[WIDTH-1-D:0], {D{1'b0}}});
    end

    if (k < LVL) begin : g_p
      logic [WIDTH-1:0] p_d, p_q;

      // Group propagate, only needed by later levels.
      always_comb begin
        p_d = p_in & {p_in[WIDTH-1-D:0], {D{1'b1}}};
      end

      // Group propagate register.
      always_ff @(posedge wb_clk_i) begin
        if (advance) begin
          p_q <= p_d;
        end
      end
    end

    // Level valid bit.
    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        v_q <= 1'b0;
      end else if (advance) begin
        v_q <= v_in;
      end
    end

    // Level datapath.
    always_ff @(posedge wb_clk_i) begin
      if (advance) begin
        g_q  <= g_d;
        po_q <= po_in;
        c0_q <= c0_in;
        am_q <= am_in;
        bm_q <= bm_in;
      end
    end
  end

  // ---------------- Stage LVL+1: sum and flags ----------------
  logic [WIDTH-1:0] c_last;
  logic [WIDTH-1:0] sum_d, out_sum_q;
  logic             cout_d, ovf_d, zero_d, valid_d;
  logic             out_cout_q, out_ovf_q, out_zero_q;

  // Final carries give sum bits; overflow from operand sign bits.
  always_comb begin
    c_last  = g_lvl[LVL].g_q;
    sum_d   = g_lvl[LVL].po_q ^ {c_last[WIDTH-2:0], g_lvl[LVL].c0_q};
    cout_d  = c_last[WIDTH-1];
    ovf_d   = (g_lvl[LVL].am_q == g_lvl[LVL].bm_q) && (sum_d[WIDTH-1] != g_lvl[LVL].am_q);
    zero_d  = ~|sum_d;
    valid_d = g_lvl[LVL].v_q;
  end

  // Output register, cleared on reset and frozen during stall.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
    end else if (advance) begin
      out_valid_q <= valid_d;
      out_sum_q   <= sum_d;
      out_cout_q  <= cout_d;
      out_ovf_q   <= ovf_d;
      out_zero_q  <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_ksa_pipe_adder.sv
// Scoreboard bench for ksa_pipe_adder at WIDTH=16.
module tb_ksa_pipe_adder;
  localparam int W   = 16;
  localparam int LAT = $clog2(W) + 1;  // clock edges from acceptance to presentation

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout, out_ovf, out_zero;

  ksa_pipe_adder #(.WIDTH(W)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .out_zero (out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    int           acc_edge;
    int           stall_at;
  } exp_t;

  exp_t q[$];
  int   errors    = 0;
  int   checks    = 0;
  int   edge_cnt  = 0;
  int   stall_cnt = 0;

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t e;
    int   full;
    int   sres;
    if (sub) begin
      full = int'(a) + (((1 << W) - 1) - int'(b)) + 1;
      sres = int'($signed(a)) - int'($signed(b));
    end else begin
      full = int'(a) + int'(b) + int'(cin);
      sres = int'($signed(a)) + int'($signed(b)) + int'(cin);
    end
    e.sum      = full[W-1:0];
    e.cout     = full[W];
    e.ovf      = (sres > ((1 << (W - 1)) - 1)) || (sres < -(1 << (W - 1)));
    e.zero     = (e.sum == '0);
    e.acc_edge = 0;
    e.stall_at = 0;
    return e;
  endfunction

  // Input side: every accepted operand set pushes its expected result.
  always @(negedge clk) begin : in_mon
    exp_t e;
    if (!rst && in_valid && in_ready) begin
      e          = model(in_a, in_b, in_cin, in_sub);
      e.acc_edge = edge_cnt + 1;
      e.stall_at = stall_cnt;
      q.push_back(e);
    end
  end

  // Output side: compare each presented result, check freeze during stall.
  logic         held = 1'b0;
  logic [W-1:0] h_sum;
  logic         h_cout, h_ovf, h_zero;

  always @(negedge clk) begin : out_mon
    if (rst) begin
      q.delete();
      held = 1'b0;
    end else begin
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid) begin
        if (held) begin
          chk("hold_sum", out_sum, h_sum);
          chk("hold_cout", out_cout, h_cout);
          chk("hold_ovf", out_ovf, h_ovf);
          chk("hold_zero", out_zero, h_zero);
        end else if (q.size() == 0) begin
          chk("unexpected_out_valid", 1'b1, 1'b0);
        end else begin
          chk("sum", out_sum, q[0].sum);
          chk("cout", out_cout, q[0].cout);
          chk("ovf", out_ovf, q[0].ovf);
          chk("zero", out_zero, q[0].zero);
          chk("latency", edge_cnt - q[0].acc_edge, LAT + (stall_cnt - q[0].stall_at));
        end
        if (out_ready) begin
          if (q.size() > 0) void'(q.pop_front());
          held = 1'b0;
        end else begin
          held   = 1'b1;
          h_sum  = out_sum;
          h_cout = out_cout;
          h_ovf  = out_ovf;
          h_zero = out_zero;
          stall_cnt++;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one operand set and hold it until accepted.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    int n;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    n        = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_sum", out_sum, '0);
    chk("rst_out_cout", out_cout, 1'b0);
    chk("rst_out_ovf", out_ovf, 1'b0);
    chk("rst_out_zero", out_zero, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed corner cases.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    idle(8);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    send(16'h0000, 16'h0001, 1'b0, 1'b1);
    send(16'h7FFF, 16'h0000, 1'b1, 1'b0);
    send(16'h0005, 16'h0003, 1'b1, 1'b1);
    send(16'h0005, 16'h0003, 1'b0, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 1'b0);
    idle(10);

    // Back-to-back random stream with the consumer always ready.
    for (int i = 0; i < 20; i++)
      send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    idle(10);

    // Directed 4-cycle backpressure once results are flowing.
    fork
      begin
        for (int i = 0; i < 12; i++)
          send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      end
      begin
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(10);

    // Random gaps and random consumer readiness.
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
          idle($urandom_range(0, 2));
        end
      end
      begin
        for (int i = 0; i < 80; i++) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    idle(12);

    // Reset with three operations in flight plus a transfer on the reset cycle.
    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    send(16'h0F0F, 16'h00FF, 1'b1, 1'b0);
    send(16'h4000, 16'h4000, 1'b0, 1'b1);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_a     = 16'hAAAA;
    in_b     = 16'h5555;
    @(negedge clk);
    chk("rst_mid_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    idle(2);
    send(16'h0101, 16'h0202, 1'b1, 1'b0);

    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    idle(8);
    chk("final_out_valid", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
